lut_sweep: RTL and testbench

LUT_SWEEP -- requirements
Module: lut_sweep

---
 rtl/lut_sweep.sv | 87 ++++++++
 tb/tb_lut_sweep.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep.sv
// lut_sweep: programmable N-input truth table swept minterm by minterm over a valid/ready stream.
// Define LUT_SWEEP_SIG_EN to add the 16-bit sweep signature output sig.
module lut_sweep #(
  parameter int N = 4,
  parameter logic [2**N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         prog_we,
  input  logic [N-1:0] prog_addr,
  input  logic         prog_data,
  input  logic         start,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] vec,
  output logic         s,
  output logic         busy,
  output logic         done,
`ifdef LUT_SWEEP_SIG_EN
  output logic [15:0]  sig,
`endif
  output logic [N:0]   ones_count
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam logic [N-1:0] LAST = {N{1'b1}};
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  state_t state;
  logic [2**N-1:0] tbl, tbl_w;
  // A write coinciding with start must already be visible to the first sample.
  always_comb begin
    tbl_w = tbl;
    if (prog_we) tbl_w[prog_addr] = prog_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      vec        <= '0;
      s          <= 1'b0;
      ones_count <= '0;
      tbl        <= INIT;
`ifdef LUT_SWEEP_SIG_EN
      sig        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          tbl  <= tbl_w;
          if (start) begin
            state      <= SWEEP;
            busy       <= 1'b1;
            valid      <= 1'b1;
            vec        <= '0;
            s          <= tbl_w[0];
            ones_count <= '0;
`ifdef LUT_SWEEP_SIG_EN
            sig        <= '0;
`endif
          end
        end
        SWEEP: if (ready) begin
          ones_count <= ones_count + {{N{1'b0}}, s};
`ifdef LUT_SWEEP_SIG_EN
          sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, s};
`endif
          if (vec == LAST) begin
            state <= DONE;
            valid <= 1'b0;
            done  <= 1'b1;
          end else begin
            vec <= vec + ONE;
            s   <= tbl[vec + ONE];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_sweep.sv
// tb_lut_sweep: table-driven sweeps plus directed corner sequences for lut_sweep (N=4, INIT=0).
module tb_lut_sweep;
  logic clk = 1'b0, reset, prog_we, prog_data, start, ready;
  logic [3:0] prog_addr, vec;
  logic valid, s, busy, done;
  logic [4:0] ones_count;
`ifdef LUT_SWEEP_SIG_EN
  logic [15:0] sig;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lut_sweep #(.N(4), .INIT(16'h0000)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .ready(ready), .valid(valid),
    .vec(vec), .s(s), .busy(busy), .done(done),
`ifdef LUT_SWEEP_SIG_EN
    .sig(sig),
`endif
    .ones_count(ones_count)
  );

  typedef struct {
    logic [15:0] tt;
    int stall_at;
    int stall_len;
    int exp_ones;
    int exp_cyc;
  } vec_t;
  vec_t tv[5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prog(input logic [15:0] t);
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_data = t[i];
      tick;
    end
    prog_we = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      tick;
      c++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic run_sweep(input vec_t r);
    int cyc, e, stalls, oc;
    prog(r.tt);
    start = 1'b1;
    ready = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    e = 0;
    stalls = 0;
    oc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      chk("sweep_valid", {31'b0, valid}, 32'd1);
      chk("sweep_vec", {28'b0, vec}, 32'(e));
      chk("sweep_s", {31'b0, s}, {31'b0, r.tt[e]});
      chk("sweep_ones", {27'b0, ones_count}, 32'(oc));
      if (e == r.stall_at && stalls < r.stall_len) begin
        ready = 1'b0;
        stalls++;
      end else begin
        ready = 1'b1;
        oc += int'(r.tt[e]);
        e++;
      end
      tick;
      cyc++;
    end
    ready = 1'b1;
    chk("done_cycle", 32'(cyc), 32'(r.exp_cyc));
    chk("final_ones", {27'b0, ones_count}, 32'(r.exp_ones));
    chk("done_valid", {31'b0, valid}, 32'd0);
    tick;
    chk("done_pulse_end", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("ones_hold", {27'b0, ones_count}, 32'(r.exp_ones));
  endtask

  initial begin
    int nd;
    tv[0] = '{16'h8000, -1, 0, 1, 17};
    tv[1] = '{16'hFFFF, -1, 0, 16, 17};
    tv[2] = '{16'h8000, 5, 3, 1, 20};
    tv[3] = '{16'hA5C3, 5, 3, 8, 20};
    tv[4] = '{16'h0000, 0, 2, 0, 19};
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = 1'b0;
    start = 1'b0; ready = 1'b0;
    tick;
    tick;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_vec", {28'b0, vec}, 32'd0);
    chk("rst_s", {31'b0, s}, 32'd0);
    chk("rst_ones", {27'b0, ones_count}, 32'd0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 5; i++) run_sweep(tv[i]);

    // Write and start in the same cycle: the sweep sees the new bit.
    prog(16'h0000);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 1'b1; start = 1'b1; ready = 1'b1;
    tick;
    prog_we = 1'b0; start = 1'b0;
    chk("wr_start_vec", {28'b0, vec}, 32'd0);
    chk("wr_start_s", {31'b0, s}, 32'd1);
    wait_done(40);
    chk("wr_start_ones", {27'b0, ones_count}, 32'd1);
    tick;

    // prog_we and start while busy are ignored.
    prog(16'h0000);
    start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("busy_pre_vec", {28'b0, vec}, 32'd2);
    prog_we = 1'b1; prog_addr = 4'd3; prog_data = 1'b1; start = 1'b1;
    tick;
    prog_we = 1'b0; start = 1'b0;
    chk("busy_no_restart", {28'b0, vec}, 32'd3);
    chk("busy_s", {31'b0, s}, 32'd0);
    chk("busy_flag", {31'b0, busy}, 32'd1);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (done === 1'b1) nd++;
    end
    chk("busy_single_done", 32'(nd), 32'd1);
    chk("busy_ones", {27'b0, ones_count}, 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(40);
    chk("busy_table_kept", {27'b0, ones_count}, 32'd0);
    tick;

    // Reset mid-sweep aborts with no done and restores INIT.
    prog(16'hFFFF);
    start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    chk("abort_pre_vec", {28'b0, vec}, 32'd7);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_valid", {31'b0, valid}, 32'd0);
    chk("abort_vec", {28'b0, vec}, 32'd0);
    chk("abort_ones", {27'b0, ones_count}, 32'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) nd++;
      tick;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(40);
    chk("abort_table_init", {27'b0, ones_count}, 32'd0);
    tick;

`ifdef LUT_SWEEP_SIG_EN
    prog(16'h0001);
    start = 1'b1; ready = 1'b1;
    tick;
    start = 1'b0;
    chk("sig_cleared", {16'b0, sig}, 32'd0);
    wait_done(40);
    chk("sig_final", {16'b0, sig}, 32'h8000);
    tick;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
